// File: rtl/frame_buffer_db.sv
// Double-buffered frame store: a frame is written into the back buffer while the
// display reads the front buffer, and the two are swapped only when the frame is complete.
module frame_buffer_db #(
  parameter  int               W         = 50,
  parameter  int               H         = 40,
  parameter  int               PIX_W     = 12,
  parameter  logic [PIX_W-1:0] BG_COLOR  = {PIX_W{1'b0}},
  localparam int               PIX_TOTAL = W * H,
  localparam int               ADDR_W    = $clog2(PIX_TOTAL),
  localparam int               CNT_W     = $clog2(PIX_TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             wr_valid,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic [9:0]       x_addr,
  input  logic [9:0]       y_addr,
  input  logic             rd_en,
  output logic [PIX_W-1:0] pixel_data,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             receiving,
  output logic             frame_done,
  output logic             frame_ready,
  output logic             front_sel
);

  localparam int AW1 = ADDR_W + 1;

  if (W < 1 || H < 1 || W > 1024 || H > 1024) begin : g_param_err
    $error("frame_buffer_db: W and H must lie in 1..1024");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_SWAP = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic [CNT_W-1:0]   pix_cnt_d;
  logic               receiving_q;
  logic               frame_done_q;
  logic               frame_ready_q;
  logic               front_sel_q;
  logic [PIX_W-1:0]   pixel_data_q;

  logic [PIX_W-1:0]   mem0 [PIX_TOTAL];
  logic [PIX_W-1:0]   mem1 [PIX_TOTAL];

  logic               accept_s;
  logic               last_s;
  logic [ADDR_W-1:0]  wr_addr_s;
  logic               rd_hit_s;
  logic [AW1-1:0]     lin_s;
  logic [ADDR_W-1:0]  rd_addr_s;

  // abort wins over a simultaneous pixel, so the pixel is neither stored nor counted
  assign accept_s  = (state_q == S_RECV) && wr_valid && !abort;
  assign last_s    = (pix_cnt_q == CNT_W'(PIX_TOTAL - 1));
  assign pix_cnt_d = pix_cnt_q + CNT_W'(1'b1);
  assign wr_addr_s = ADDR_W'(pix_cnt_q);

  // Bounds are checked on the full 10-bit coordinates; the linear index is only used when in range
  assign rd_hit_s  = rd_en && frame_ready_q &&
                     ({1'b0, x_addr} < 11'(W)) && ({1'b0, y_addr} < 11'(H));
  assign lin_s     = AW1'(y_addr) * AW1'(W) + AW1'(x_addr);
  assign rd_addr_s = lin_s[ADDR_W-1:0];

  // Reception / swap controller with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= {CNT_W{1'b0}};
      receiving_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      front_sel_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_RECV;
            pix_cnt_q   <= {CNT_W{1'b0}};
            receiving_q <= 1'b1;
          end
        end
        S_RECV: begin
          if (abort) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= {CNT_W{1'b0}};
            receiving_q <= 1'b0;
          end else if (wr_valid) begin
            pix_cnt_q <= pix_cnt_d;
            if (last_s) begin
              state_q     <= S_SWAP;
              receiving_q <= 1'b0;
            end
          end
        end
        S_SWAP: begin
          front_sel_q   <= ~front_sel_q;
          frame_ready_q <= 1'b1;
          frame_done_q  <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          receiving_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer 0 write port: written only while it is the back buffer
  always_ff @(posedge clk) begin
    if (accept_s && front_sel_q) begin
      mem0[wr_addr_s] <= wr_data;
    end
  end

  // Buffer 1 write port: written only while it is the back buffer
  always_ff @(posedge clk) begin
    if (accept_s && !front_sel_q) begin
      mem1[wr_addr_s] <= wr_data;
    end
  end

  // Registered read of the front buffer; front_sel_q flips only after the swap cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data_q <= BG_COLOR;
    end else if (rd_hit_s) begin
      pixel_data_q <= front_sel_q ? mem1[rd_addr_s] : mem0[rd_addr_s];
    end else begin
      pixel_data_q <= BG_COLOR;
    end
  end

  assign wr_ready    = (state_q == S_RECV);
  assign pixel_data  = pixel_data_q;
  assign pix_cnt     = pix_cnt_q;
  assign receiving   = receiving_q;
  assign frame_done  = frame_done_q;
  assign frame_ready = frame_ready_q;
  assign front_sel   = front_sel_q;

endmodule

// File: tb/tb_frame_buffer_db.sv
// Directed bench for frame_buffer_db (W=4, H=3): a vector table for the first frame
// and reads, then hand sequences for gaps, abort, ignored controls, back-to-back and reset.
module tb_frame_buffer_db;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_data = 12'h000;
  logic        wr_ready;
  logic [9:0]  x_addr = 10'd0;
  logic [9:0]  y_addr = 10'd0;
  logic        rd_en = 1'b0;
  logic [11:0] pixel_data;
  logic [3:0]  pix_cnt;
  logic        receiving;
  logic        frame_done;
  logic        frame_ready;
  logic        front_sel;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  frame_buffer_db #(.W(4), .H(3), .PIX_W(12), .BG_COLOR(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .x_addr(x_addr), .y_addr(y_addr), .rd_en(rd_en), .pixel_data(pixel_data),
    .pix_cnt(pix_cnt), .receiving(receiving), .frame_done(frame_done),
    .frame_ready(frame_ready), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ab, wv;
    logic [11:0] wd;
    logic [9:0]  x, y;
    logic        re;
    logic [11:0] e_pd;
    logic [3:0]  e_cnt;
    logic        e_rcv, e_fd, e_fr, e_fs, e_wrdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic ab, input logic wv, input logic [11:0] wd,
                              input logic [9:0] x, input logic [9:0] y, input logic re,
                              input logic [11:0] pd, input logic [3:0] cnt, input logic rcv,
                              input logic fd, input logic fr, input logic fs, input logic wrdy);
    vec_t v;
    v.st = st; v.ab = ab; v.wv = wv; v.wd = wd; v.x = x; v.y = y; v.re = re;
    v.e_pd = pd; v.e_cnt = cnt; v.e_rcv = rcv; v.e_fd = fd; v.e_fr = fr; v.e_fs = fs; v.e_wrdy = wrdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string p, input logic [11:0] pd, input logic [3:0] cnt, input logic rcv,
                         input logic fd, input logic fr, input logic fs, input logic wrdy);
    chk({p, "_pixel_data"}, pixel_data, pd);
    chk({p, "_pix_cnt"}, pix_cnt, cnt);
    chk({p, "_receiving"}, receiving, rcv);
    chk({p, "_frame_done"}, frame_done, fd);
    chk({p, "_frame_ready"}, frame_ready, fr);
    chk({p, "_front_sel"}, front_sel, fs);
    chk({p, "_wr_ready"}, wr_ready, wrdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic rd_at(input int idx);
    rd_en  = 1'b1;
    x_addr = 10'(idx % 4);
    y_addr = 10'(idx / 4);
  endtask

  task automatic push_pixel(input logic [11:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_base;

    // Frame 1 (12'h001..12'h00C) and reads of the completed frame
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0, 1'b1, 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0, 1'b0, 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 12; k++) begin
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 12'(k + 1), 10'd0, 10'd0, 1'b0, 12'h000, 4'(k + 1),
                       (k < 11), 1'b0, 1'b0, 1'b0, (k < 11)));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0, 1'b0, 12'h000, 4'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd3, 10'd2, 1'b1, 12'h00C, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd4, 10'd0, 1'b1, 12'h000, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0, 1'b1, 12'h001, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd1, 10'd1, 1'b1, 12'h006, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd3, 10'd3, 1'b1, 12'h000, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'd0, 10'd0, 1'b0, 12'h000, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 12'h000, 10'd2, 10'd0, 1'b1, 12'h003, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 12'h000, 10'h3FF, 10'd0, 1'b1, 12'h000, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));

    // Reset state
    tick();
    tick();
    chk_all("reset", 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].st; abort = tbl[i].ab; wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
      x_addr = tbl[i].x; y_addr = tbl[i].y; rd_en = tbl[i].re;
      tick();
      chk_all($sformatf("v%0d", i), tbl[i].e_pd, tbl[i].e_cnt, tbl[i].e_rcv, tbl[i].e_fd,
              tbl[i].e_fr, tbl[i].e_fs, tbl[i].e_wrdy);
    end
    start = 1'b0; abort = 1'b0; wr_valid = 1'b0;

    // Frame 2 with gaps; (0,0) shows frame 1 until the read issued after the swap cycle
    rd_at(0);
    fd_base = fd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f2_start_rd", pixel_data, 12'h001);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("f2_gap%0d_rd", i), pixel_data, 12'h001);
      push_pixel(12'h101 + 12'(i));
      chk($sformatf("f2_pix%0d_rd", i), pixel_data, 12'h001);
    end
    chk("f2_cnt", pix_cnt, 32'd12);
    chk("f2_rcv_low", receiving, 1'b0);
    chk("f2_no_early_done", fd_cnt, fd_base);
    tick();
    chk("f2_swap_rd_old", pixel_data, 12'h001);
    chk("f2_done", frame_done, 1'b1);
    chk("f2_front_sel", front_sel, 1'b0);
    tick();
    chk("f2_rd_new", pixel_data, 12'h101);
    chk("f2_done_pulse", frame_done, 1'b0);

    // Abort after 5 pixels, with a pixel presented in the abort cycle
    fd_base = fd_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) push_pixel(12'h201 + 12'(i));
    chk("ab_cnt5", pix_cnt, 32'd5);
    chk("ab_rcv", receiving, 1'b1);
    abort = 1'b1;
    push_pixel(12'h2FF);
    abort = 1'b0;
    chk("ab_cnt0", pix_cnt, 32'd0);
    chk("ab_rcv0", receiving, 1'b0);
    chk("ab_wrdy0", wr_ready, 1'b0);
    tick();
    tick();
    tick();
    chk("ab_no_done", fd_cnt, fd_base);
    chk("ab_rd_prev", pixel_data, 12'h101);
    chk("ab_front_sel", front_sel, 1'b0);
    chk("ab_frame_ready", frame_ready, 1'b1);

    // Pixels in IDLE are dropped; start in RECV and SWAP is ignored
    for (int i = 0; i < 3; i++) push_pixel(12'hEEE);
    chk("idle_cnt", pix_cnt, 32'd0);
    chk("idle_wrdy", wr_ready, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) push_pixel(12'h301 + 12'(i));
    start = 1'b1;
    push_pixel(12'h307);
    start = 1'b0;
    chk("recv_start_cnt", pix_cnt, 32'd7);
    chk("recv_start_rcv", receiving, 1'b1);
    for (int i = 7; i < 12; i++) push_pixel(12'h301 + 12'(i));
    chk("f4_cnt", pix_cnt, 32'd12);
    start = 1'b1;
    push_pixel(12'hBAD);
    start = 1'b0;
    chk("swap_done", frame_done, 1'b1);
    chk("swap_front_sel", front_sel, 1'b1);
    chk("swap_start_ignored", receiving, 1'b0);
    chk("swap_pix_dropped", pix_cnt, 32'd12);

    // Back-to-back: start right after the swap; read frame 4 while frame 5 is written
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_rcv", receiving, 1'b1);
    chk("b2b_cnt", pix_cnt, 32'd0);
    chk("b2b_wrdy", wr_ready, 1'b1);
    for (int j = 0; j < 7; j++) begin
      rd_at(11 - j);
      push_pixel(12'h401 + 12'(j));
      chk($sformatf("f4_rd%0d", 11 - j), pixel_data, 12'h301 + 12'(11 - j));
    end
    chk("f5_cnt7", pix_cnt, 32'd7);

    // Asynchronous reset mid-reception
    rst_n = 1'b0;
    #1;
    chk_all("arst", 12'h000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    rd_at(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_rd%0d", i), pixel_data, 12'h000);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_pixel(12'h501 + 12'(i));
      chk($sformatf("f6_rd%0d", i), pixel_data, 12'h000);
    end
    tick();
    chk("f6_swap_rd", pixel_data, 12'h000);
    chk("f6_front_sel", front_sel, 1'b1);
    chk("f6_frame_ready", frame_ready, 1'b1);
    tick();
    chk("f6_rd_new", pixel_data, 12'h501);
    chk("total_done_pulses", fd_cnt, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_db.md
Name: frame_buffer_db

Overview:
- Parametrised, double-buffered image store for the photo-frame datapath.
- Sits between the UART pixel deserialiser and the VGA display timing generator.
- Receives one frame of PIX_W-bit pixels into a back buffer while the display reads a front buffer.
- Swaps the buffers atomically on frame completion, so the display never shows a partially received image; an aborted transfer leaves the shown image intact.

Parameters:
- W, 50: image width in pixels.
- H, 40: image height in pixels.
- PIX_W, 12: pixel width in bits (RGB444 at default).
- BG_COLOR, 0: value driven on pixel_data outside the image or when no frame is valid.
- Derived, not overridable:
  - PIX_TOTAL = W*H
  - ADDR_W = clog2(PIX_TOTAL)
  - CNT_W = clog2(PIX_TOTAL+1)

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins reception of a new frame.
- abort  in  1  pulse; cancels the reception in progress.
- wr_valid  in  1  wr_data valid.
- wr_data  in  PIX_W  incoming pixel, raster order.
- wr_ready  out  1  block accepts a pixel this cycle.
- x_addr  in  10  display column.
- y_addr  in  10  display row.
- rd_en  in  1  display active region.
- pixel_data  out  PIX_W  registered read data.
- pix_cnt  out  CNT_W  pixels accepted in the current frame.
- receiving  out  1  reception in progress.
- frame_done  out  1  one-cycle pulse on buffer swap.
- frame_ready  out  1  front buffer holds a complete frame.
- front_sel  out  1  index of the buffer currently displayed.

Behaviour:
- Reset (async assert, sync release): all outputs are reset; RAM contents are not.
  - state=IDLE; pix_cnt=0; receiving=0; frame_done=0; frame_ready=0; front_sel=0; pixel_data=BG_COLOR.
- Storage: two arrays of PIX_TOTAL x PIX_W. Back buffer = !front_sel.
- FSM:
  - IDLE:
    - start=1 -> RECV with pix_cnt<=0, receiving<=1.
    - Otherwise hold. abort is ignored.
  - RECV:
    - wr_ready=1 (combinational from state).
    - Each cycle with wr_valid=1 writes back[pix_cnt]<=wr_data and increments pix_cnt.
    - When the accepted pixel has pix_cnt==PIX_TOTAL-1: go to SWAP, receiving<=0. pix_cnt ends at PIX_TOTAL.
    - abort=1 -> IDLE, receiving<=0, pix_cnt<=0. Front buffer, front_sel and frame_ready are unchanged.
    - abort has priority over a simultaneous wr_valid: that pixel is not written.
    - start while in RECV is ignored; reception does not restart.
  - SWAP (exactly one cycle):
    - front_sel<=~front_sel; frame_ready<=1; frame_done<=1 for this cycle only.
    - Next state IDLE. wr_ready=0.
    - start is ignored in SWAP.
- pix_cnt holds its value in IDLE until the next start, so software can read the final count.
- wr_ready=0 in IDLE and SWAP. Pixels presented there are dropped and not counted.
- Read path (latency 1 cycle):
  - If rd_en && frame_ready && x_addr<W && y_addr<H, then pixel_data<=front[y_addr*W+x_addr].
  - Otherwise pixel_data<=BG_COLOR.
  - Address arithmetic: compute at ADDR_W+1 bits; no truncation before the bounds check.
- Swap timing:
  - A read issued in the SWAP cycle returns data from the old front buffer.
  - Reads from the cycle after SWAP use the new front buffer.
  - No read ever returns data from a buffer being written.
- Reset mid-reception: FSM returns to IDLE and frame_ready=0, so the display shows BG_COLOR until the next complete frame.
- Back-to-back frames: start in the cycle after SWAP (in IDLE) is accepted. The next frame writes the other buffer.
- Width rules: x_addr and y_addr are fixed at 10 bits. W and H must be <=1024; elaboration fails otherwise.

Test Plan:
(Bench uses W=4, H=3, PIX_W=12, BG_COLOR=12'h000.)
- Reset, then read (0,0) with rd_en=1 -> pixel_data=12'h000, frame_ready=0, wr_ready=0.
- start, then 12 consecutive wr_valid pixels 12'h001..12'h00C:
  - frame_done pulses once, 1 cycle after the 12th pixel; front_sel=1; pix_cnt=12.
  - Read (3,2) -> 12'h00C one cycle later; read (4,0) -> 12'h000.
- Second frame 12'h101..12'h10C with wr_valid gaps, reading (0,0) throughout reception -> 12'h001 until the SWAP cycle's read, then 12'h101.
- start, 5 pixels, abort asserted with wr_valid=1 -> pix_cnt=0, receiving=0, no frame_done; read (0,0) still returns the previous frame's value.
- wr_valid pulses in IDLE and start during RECV -> no write, pix_cnt unchanged, frame continues to complete normally.
- Assert rst_n=0 after 7 pixels -> all outputs at reset values immediately (asynchronously); subsequent reads return 12'h000 until a full frame completes.
